srl_seq: RTL and testbench

//  Multi-cycle logical/arithmetic right shifter; the right-shift counterpart of the

---
 rtl/srl_seq_if.sv | 37 +++
 rtl/srl_seq.sv | 108 ++++++++++
 tb/tb_srl_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/srl_seq_if.sv
// Start/result bus between the multi-cycle control unit and the iterative right shifter.
// Purely structural: carries the request operands one way and the result/status the other.
// The control unit drives the master side; the shifter sits on the slave side.
interface srl_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] rt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] rd;
  logic             busy;
  logic             done;

  // Control unit: issues requests and consumes results
  modport master (
    output start,
    output arith,
    output rt,
    output shamt,
    input  rd,
    input  busy,
    input  done
  );

  // Shifter: accepts requests and produces results
  modport slave (
    input  start,
    input  arith,
    input  rt,
    input  shamt,
    output rd,
    output busy,
    output done
  );
endinterface

// File: rtl/srl_seq.sv
// Purpose: multi-cycle logical (srl) / arithmetic (sra) right shifter with start/done handshake.
// Latency: shamt+1 cycles from start edge to done (shamt/4 + shamt%4 + 1 with SRL_SKIP4_EN defined).
// Backpressure: none queued; start is ignored while busy (SHIFT or DONE), caller must wait for done.
module srl_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  srl_seq_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             fill_q,  fill_d;
  logic [WIDTH-1:0] rd_q,    rd_d;
  logic             done_q,  done_d;

  // Single-bit step: the fill bit chosen at capture enters from the top
  logic [WIDTH-1:0] acc_sh1;
  assign acc_sh1 = {fill_q, acc_q[WIDTH-1:1]};

`ifdef SRL_SKIP4_EN
  // Four-bit step used while at least four positions remain
  logic [WIDTH-1:0] acc_sh4;
  logic             cnt_ge4;
  assign acc_sh4 = {{4{fill_q}}, acc_q[WIDTH-1:4]};
  assign cnt_ge4 = (cnt_q[SHW-1:2] != '0);
`endif

  // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Operands and fill are frozen here; later input changes cannot disturb the run
          acc_d   = bus.rt;
          cnt_d   = bus.shamt;
          fill_d  = bus.arith & bus.rt[WIDTH-1];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
`ifdef SRL_SKIP4_EN
          if (cnt_ge4) begin
            acc_d = acc_sh4;
            cnt_d = cnt_q - SHW'(4);
          end else begin
            acc_d = acc_sh1;
            cnt_d = cnt_q - SHW'(1);
          end
`else
          acc_d = acc_sh1;
          cnt_d = cnt_q - SHW'(1);
`endif
        end else begin
          // Count exhausted: publish result and pulse done for one cycle
          rd_d    = acc_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Start seen here is dropped; the next request is taken from IDLE
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset dominates any start in the same cycle and aborts a run in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign bus.rd   = rd_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_srl_seq.sv
// Directed plus randomized checks of srl_seq against a plain-arithmetic shift reference.
// Operations are issued from a negedge; outputs are sampled on negedges.
// Latency expectation follows SRL_SKIP4_EN when the bench is built with it.
module tb_srl_seq;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  srl_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  srl_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: behavioural shift operators on whole words
  function automatic logic [WIDTH-1:0] ref_shift(input logic ar, input logic [WIDTH-1:0] v,
                                                 input logic [SHW-1:0] sh);
    logic signed [WIDTH-1:0] s;
    s = v;
    if (ar) return WIDTH'(s >>> sh);
    return v >> sh;
  endfunction

  function automatic int ref_lat(input logic [SHW-1:0] sh);
`ifdef SRL_SKIP4_EN
    return int'(sh) / 4 + int'(sh) % 4 + 1;
`else
    return int'(sh) + 1;
`endif
  endfunction

  // Issue one operation from the current negedge, wait for done, check result/latency/pulse.
  // Returns at a negedge with the shifter back in IDLE, so a follow-up call is back-to-back.
  task automatic run_op(input string tag, input logic ar, input logic [WIDTH-1:0] v,
                        input logic [SHW-1:0] sh, input logic [WIDTH-1:0] exp_rd);
    int lat;
    bus.start = 1'b1;
    bus.arith = ar;
    bus.rt    = v;
    bus.shamt = sh;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rt    = $urandom;
    bus.shamt = SHW'($urandom);
    bus.arith = 1'($urandom);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(ref_lat(sh)));
    check({tag, "_rd"}, 64'(bus.rd), 64'(exp_rd));
    @(negedge clk);
    check({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, "_hold"}, 64'(bus.rd), 64'(exp_rd));
  endtask

  initial begin
    logic [WIDTH-1:0] r_rt;
    logic [SHW-1:0]   r_sh;
    logic             r_ar;
    int               seen;

    // Reset, with start asserted to show reset wins
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.arith = 1'b0;
    bus.rt    = 32'hDEAD_BEEF;
    bus.shamt = 5'd3;
    repeat (3) @(negedge clk);
    check("reset", {bus.rd, 30'd0, bus.busy, bus.done}, 64'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("reset_idle", 64'(bus.busy), 64'd0);

    // Directed cases
    run_op("srl1", 1'b0, 32'hFFFF_FFFF, 5'd1, 32'h7FFF_FFFF);
    run_op("sra31", 1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("srl31", 1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001);
    run_op("srl0", 1'b0, 32'h1234_5678, 5'd0, 32'h1234_5678);

    // Start while busy is ignored; changing operands mid-run has no effect
    bus.start = 1'b1; bus.arith = 1'b0; bus.rt = 32'hFFFF_FFFF; bus.shamt = 5'd3;
    @(negedge clk);
    bus.rt = 32'h0; bus.shamt = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    while (bus.done !== 1'b1 && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("busy_ign_rd", 64'(bus.rd), 64'h1FFF_FFFF);
    check("busy_ign_lat", 64'(seen + 1), 64'(ref_lat(5'd3)));
    // Start presented during the DONE cycle must also be dropped
    bus.start = 1'b1; bus.rt = 32'h0000_00F0; bus.shamt = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_ign_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("done_ign_nodone", {62'd0, bus.done, bus.busy}, 64'd0);
    check("done_ign_rd", 64'(bus.rd), 64'h1FFF_FFFF);

    // Reset mid-operation aborts and drops the result
    bus.start = 1'b1; bus.arith = 1'b0; bus.rt = 32'hAAAA_5555; bus.shamt = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort", {bus.rd, 30'd0, bus.busy, bus.done}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    run_op("post_abort", 1'b1, 32'hC000_0000, 5'd2, 32'hF000_0000);

    // Back-to-back sra then srl of the same operand
    run_op("b2b_sra", 1'b1, 32'hF000_0000, 5'd4, 32'hFF00_0000);
    run_op("b2b_srl", 1'b0, 32'hF000_0000, 5'd4, 32'h0F00_0000);

    // Randomized operations against the reference shift
    for (int i = 0; i < 40; i++) begin
      r_rt = $urandom;
      r_sh = SHW'($urandom);
      r_ar = 1'($urandom);
      if (i % 8 == 0) r_rt[WIDTH-1] = 1'b1;
      run_op($sformatf("rnd%0d", i), r_ar, r_rt, r_sh, ref_shift(r_ar, r_rt, r_sh));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
